// File: rtl/pwm_ramp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pwm_ramp_ctrl_pkg
//  Brief   : Shared types and constants for the PWM duty ramp controller.
//  Revision: 1.0  initial release
// ============================================================================
package pwm_ramp_ctrl_pkg;

    localparam int c_DUTY_W  = 10;
    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_period_tick.sv
`default_nettype none
// ============================================================================
//  Module  : pwm_period_tick
//  Brief   : Free-running PWM period counter and ramp prescaler; emits upd.
//  Revision: 1.0  initial release
// ============================================================================
module pwm_period_tick #(
    parameter int PERIOD   = 10,
    parameter int RAMP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_upd
);

    localparam int c_CNT_W = (PERIOD   > 1) ? $clog2(PERIOD)   : 1;
    localparam int c_DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_DIV_W-1:0] r_pre;
    logic               w_tick;
    logic               w_pre_last;

    assign w_tick     = (r_cnt == c_CNT_W'(PERIOD - 1));
    assign w_pre_last = (r_pre == c_DIV_W'(RAMP_DIV - 1));
    assign o_upd      = w_tick & w_pre_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_pre <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_pre <= w_pre_last ? '0 : r_pre + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : pwm_ramp_ctrl
//  Brief   : Rate-limited PWM duty sequencer with run/stop and latched fault.
//  Revision: 1.0  initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int DUTY_W   = c_DUTY_W,
    parameter int PERIOD   = 10,
    parameter int STEP     = 1,
    parameter int RAMP_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              tgt_valid,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ready,
    input  logic              fault,
    input  logic              fault_clr,
    output logic              pwm_en,
    output logic [DUTY_W-1:0] pwm_d,
    output logic              at_target,
    output logic              faulted
);

    localparam logic [DUTY_W-1:0] c_PERIOD = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] c_STEP   = DUTY_W'(STEP);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_pwm_d;
    logic [DUTY_W-1:0] w_pwm_d_nxt;
    logic [DUTY_W-1:0] w_eff;
    logic [DUTY_W-1:0] w_diff;
    logic [DUTY_W-1:0] w_stepped;
    logic              w_upd;
    logic              w_accept;
    logic              w_active;

    pwm_period_tick #(
        .PERIOD   (PERIOD),
        .RAMP_DIV (RAMP_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .o_upd (w_upd)
    );

    assign tgt_ready = (r_state != ST_FAULT) & ~fault;
    assign w_accept  = tgt_valid & tgt_ready;
    assign w_active  = (r_state == ST_RAMP) | (r_state == ST_HOLD) | (r_state == ST_STOP);

    assign pwm_en    = w_active;
    assign pwm_d     = r_pwm_d;
    assign at_target = (r_state == ST_HOLD);
    assign faulted   = (r_state == ST_FAULT);

    // Slew toward the effective target; the step never crosses it, so no wrap.
    always_comb begin
        w_eff       = (r_state == ST_STOP) ? '0 : r_target;
        w_diff      = (w_eff >= r_pwm_d) ? (w_eff - r_pwm_d) : (r_pwm_d - w_eff);
        w_stepped   = r_pwm_d;
        w_pwm_d_nxt = r_pwm_d;
        if (w_diff <= c_STEP) begin
            w_stepped = w_eff;
        end else if (w_eff > r_pwm_d) begin
            w_stepped = r_pwm_d + c_STEP;
        end else begin
            w_stepped = r_pwm_d - c_STEP;
        end
        if (fault) begin
            w_pwm_d_nxt = '0;
        end else if (w_upd && w_active) begin
            w_pwm_d_nxt = w_stepped;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (fault) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE:  if (run) w_state_nxt = ST_RAMP;
                ST_RAMP: begin
                    if (!run)                          w_state_nxt = ST_STOP;
                    else if (w_pwm_d_nxt == r_target)  w_state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!run)                          w_state_nxt = ST_STOP;
                    else if (r_target != r_pwm_d)      w_state_nxt = ST_RAMP;
                end
                ST_STOP: begin
                    if (run)                           w_state_nxt = ST_RAMP;
                    else if (r_pwm_d == '0)            w_state_nxt = ST_IDLE;
                end
                ST_FAULT: if (fault_clr)               w_state_nxt = ST_IDLE;
                default:                               w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_pwm_d  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pwm_d <= w_pwm_d_nxt;
            if (w_accept) begin
                r_target <= (tgt_duty > c_PERIOD) ? c_PERIOD : tgt_duty;
            end
        end
    end

endmodule
`default_nettype wire
